decode_ctrl_pipe: RTL and testbench
===================================

# decode_ctrl_pipe

Registered decode/control stage for the five-stage pipeline: decodes one 32-bit RV-style instruction per cycle into the EX/MEM/WB control bundles and a sign-extended immediate, and holds them in the ID/EX pipeline register. It extends the combinational control unit in four ways:
- parametrised datapath width;
- JAL/JALR link and LUI support;
- load-use hazard detection with bubble insertion;
- flush/stall handling, plus a saturating stall counter and an illegal-instruction flag.

## Interface
Parameters:
- DATA_W, 64, immediate output width (sign-extended)
- PC_W, 32, PC width
- JALR_EN, 1, 1 = decode opcode 11001 as JALR; 0 = treat it as illegal
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction
- if_pc  in  PC_W  PC of if_instr
- id_ready  out  1  combinational; instruction accepted when if_valid & id_ready
- ex_stall  in  1  downstream hold; ID/EX register keeps its value
- ex_flush  in  1  branch/jump taken in MEM; ID/EX register loads a bubble and the incoming instruction is dropped
- ex_valid  out  1  ID/EX register holds a real instruction
- ex_pc  out  PC_W  registered PC
- ex_rs1, ex_rs2, ex_rd  out  5 each  register addresses
- ex_imm  out  DATA_W  sign-extended immediate
- ex_ctrl_ex  out  6  {ALUSrc, ALU_OP[3:0], RegDst}
- ex_ctrl_mem  out  4  {Branch[1:0], Jump, MemWrite}; Branch 00 BEQ, 01 BNE, 10 BLT, 11 none
- ex_ctrl_wb  out  2  {MemtoReg, RegWrite}
- ex_link  out  1  write PC+4 to rd (JAL/JALR)
- ex_jalr  out  1  target = rs1+imm rather than PC+imm
- ex_illegal  out  1  registered instruction was undecodable (ex_valid = 0)
- illegal_seen  out  1  sticky; cleared only by reset
- stall_cnt  out  CNT_W  saturating count of load-use bubbles

## Operation
- Bubble encoding, used for reset, flush, hazard and illegal: ex_valid 0; rs/rd 0; imm 0; ex_ctrl_ex 0; ex_ctrl_mem 4'b1100; ex_ctrl_wb 0; link 0; jalr 0.
- Decode is keyed on opcode = instr[6:2] and f3 = instr[14:12]. Immediates are sign-extended from instr[31]. B- and J-immediates carry bit0 = 0, so they are byte offsets.
- 00000 LOAD: imm I; ALUSrc 1; ALU_OP 0000; RegDst 1; MemtoReg 1; RegWrite 1.
- 01000 STORE: imm S; ALUSrc 1; ALU_OP 0000; RegDst 0; MemWrite 1; RegWrite 0.
- 00100 OP-IMM: imm I; ALUSrc 1; ALU_OP {f3==101 ? instr[30] : 0, f3}; RegWrite 1.
- 01100 R-type: imm 0; ALUSrc 0; ALU_OP {instr[30], f3}; RegWrite 1.
- 01101 LUI: imm {instr[31:12], 12'b0} sign-extended; ex_rs1 forced to 0; ALUSrc 1; ALU_OP 0000; RegWrite 1.
- 11000 BRANCH: imm B; ALU_OP 1000; Branch {instr[14], instr[12]}; RegWrite 0.
  - f3 must be 000, 001 or 100; any other f3 is illegal.
- 11011 JAL: imm J; Jump 1; link 1; RegWrite 1.
- 11001 JALR (JALR_EN=1 only): imm I; ALUSrc 1; Jump 1; link 1; jalr 1; RegWrite 1.
- Illegal instruction (any other opcode, or the illegal cases above):
  - register loads a bubble with ex_illegal = 1 for one register cycle;
  - illegal_seen is set;
  - the instruction counts as accepted.
- Load-use hazard is asserted when all of the following hold:
  - ex_valid;
  - ex_ctrl_wb[1] (the instruction in ID/EX is a load);
  - ex_rd != 0;
  - if_valid;
  - ex_rd equals any rs the incoming instruction uses. rs1 is used by all except LUI/JAL; rs2 by R-type, STORE and BRANCH.
- id_ready = ~ex_stall & ~hazard. During ex_flush, id_ready = 1 and the instruction is discarded.
- Register update priority: flush > stall > hazard (load bubble, stall_cnt += 1 saturating) > if_valid (load decode) > bubble.

## Timing
- Reset (rst_n low, asynchronous): all ex_* outputs take the bubble encoding; illegal_seen 0; stall_cnt 0.
- Latency: 1 cycle. An instruction accepted at edge N appears on ex_* after edge N.
- Load-use timing:
  - cycle with hazard: id_ready 0, and a bubble is registered at the edge;
  - next cycle: the hazard is clear because ex_valid = 0, so the instruction is accepted.
  - Exactly one bubble is inserted per load-use pair.
- Hazard + ex_stall: stall wins; the register holds, stall_cnt does not increment.
- Flush + stall: flush wins; a bubble is loaded.
- stall_cnt stops at 2^CNT_W−1 with no wrap.
- rd = 0 loads never cause a hazard.
- if_valid = 0 with no stall/flush: a bubble is loaded.

## Test plan
- Reset with rst_n = 0 mid-stream → next sample shows ex_valid 0, ex_ctrl_mem 1100, stall_cnt 0, illegal_seen 0.
- Sequence ADDI x1,x0,-5 then BEQ (imm −8) → ADDI: ex_imm all-ones…FB, RegWrite 1. BEQ one cycle later: ex_imm −8, Branch 00, RegWrite 0.
- LD x5,0(x2) then ADD x6,x5,x7 →
  - id_ready 0 for exactly one cycle;
  - one bubble between the two;
  - ADD reaches ex_* 2 cycles after LD;
  - stall_cnt = 1.
  - Repeat with rd = x0: no bubble.
- JALR x1,8(x3), JALR_EN=1 → Jump 1, link 1, jalr 1, imm 8. With JALR_EN=0 → ex_illegal pulse, ex_valid 0, illegal_seen stays 1.
- Flush asserted together with a valid LW and with ex_stall = 1 → register loads a bubble, id_ready 1, LW never appears.
- CNT_W = 2 with five load-use pairs → stall_cnt saturates at 3.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// ID stage of the five-stage pipeline: decodes one instruction per cycle into
// EX/MEM/WB control bundles plus immediate, held in the ID/EX register.
module decode_ctrl_pipe #(
  parameter int DATA_W  = 64,
  parameter int PC_W    = 32,
  parameter int JALR_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  output logic              id_ready,
  input  logic              ex_stall,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_imm,
  output logic [5:0]        ex_ctrl_ex,
  output logic [3:0]        ex_ctrl_mem,
  output logic [1:0]        ex_ctrl_wb,
  output logic              ex_link,
  output logic              ex_jalr,
  output logic              ex_illegal,
  output logic              illegal_seen,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  logic [4:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_immI;
  logic [DATA_W-1:0] w_immS;
  logic [DATA_W-1:0] w_immB;
  logic [DATA_W-1:0] w_immJ;
  logic [DATA_W-1:0] w_immU;
  logic [DATA_W-1:0] w_imm;
  logic              w_aluSrc;
  logic [3:0]        w_aluOp;
  logic              w_regDst;
  logic [1:0]        w_branch;
  logic              w_jump;
  logic              w_memWrite;
  logic              w_memToReg;
  logic              w_regWrite;
  logic              w_link;
  logic              w_jalr;
  logic              w_illegal;
  logic              w_useRs1;
  logic              w_useRs2;
  logic              w_hazard;
  logic              w_accept;
  logic              w_take;
  logic              w_markIllegal;
  logic              w_countStall;
  logic              w_unusedBits;

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_imm;
  logic [5:0]        r_ctrlEx;
  logic [3:0]        r_ctrlMem;
  logic [1:0]        r_ctrlWb;
  logic              r_link;
  logic              r_jalr;
  logic              r_illegal;
  logic              r_illegalSeen;
  logic [CNT_W-1:0]  r_stallCnt;

  assign w_opcode     = if_instr[6:2];
  assign w_f3         = if_instr[14:12];
  assign w_rs2        = if_instr[24:20];
  assign w_rd         = if_instr[11:7];
  assign w_unusedBits = ^if_instr[1:0];

  assign w_immI = {{(DATA_W-12){if_instr[31]}}, if_instr[31:20]};
  assign w_immS = {{(DATA_W-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign w_immB = {{(DATA_W-13){if_instr[31]}}, if_instr[31], if_instr[7],
                   if_instr[30:25], if_instr[11:8], 1'b0};
  assign w_immJ = {{(DATA_W-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                   if_instr[20], if_instr[30:21], 1'b0};
  assign w_immU = {{(DATA_W-32){if_instr[31]}}, if_instr[31:12], 12'b0};

  always_comb begin
    w_imm      = '0;
    w_rs1      = if_instr[19:15];
    w_aluSrc   = 1'b0;
    w_aluOp    = 4'b0000;
    w_regDst   = 1'b0;
    w_branch   = 2'b11;
    w_jump     = 1'b0;
    w_memWrite = 1'b0;
    w_memToReg = 1'b0;
    w_regWrite = 1'b0;
    w_link     = 1'b0;
    w_jalr     = 1'b0;
    w_illegal  = 1'b0;
    w_useRs1   = 1'b1;
    w_useRs2   = 1'b0;
    case (w_opcode)
      OP_LOAD: begin
        w_imm      = w_immI;
        w_aluSrc   = 1'b1;
        w_regDst   = 1'b1;
        w_memToReg = 1'b1;
        w_regWrite = 1'b1;
      end
      OP_STORE: begin
        w_imm      = w_immS;
        w_aluSrc   = 1'b1;
        w_memWrite = 1'b1;
        w_useRs2   = 1'b1;
      end
      OP_IMM: begin
        w_imm      = w_immI;
        w_aluSrc   = 1'b1;
        w_aluOp    = {(w_f3 == 3'b101) ? if_instr[30] : 1'b0, w_f3};
        w_regWrite = 1'b1;
      end
      OP_REG: begin
        w_aluOp    = {if_instr[30], w_f3};
        w_regWrite = 1'b1;
        w_useRs2   = 1'b1;
      end
      OP_LUI: begin
        w_imm      = w_immU;
        w_rs1      = 5'd0;
        w_aluSrc   = 1'b1;
        w_regWrite = 1'b1;
        w_useRs1   = 1'b0;
      end
      OP_BRANCH: begin
        w_imm     = w_immB;
        w_aluOp   = 4'b1000;
        w_branch  = {if_instr[14], if_instr[12]};
        w_useRs2  = 1'b1;
        w_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b100));
      end
      OP_JAL: begin
        w_imm      = w_immJ;
        w_jump     = 1'b1;
        w_link     = 1'b1;
        w_regWrite = 1'b1;
        w_useRs1   = 1'b0;
      end
      OP_JALR: begin
        if (JALR_EN != 0) begin
          w_imm      = w_immI;
          w_aluSrc   = 1'b1;
          w_jump     = 1'b1;
          w_link     = 1'b1;
          w_jalr     = 1'b1;
          w_regWrite = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // A load in ID/EX whose rd feeds the incoming instruction forces one bubble.
  assign w_hazard = r_valid & r_ctrlWb[1] & (r_rd != 5'd0) & if_valid &
                    ((w_useRs1 & (w_rs1 == r_rd)) | (w_useRs2 & (w_rs2 == r_rd)));

  assign id_ready      = ex_flush | (~ex_stall & ~w_hazard);
  assign w_accept      = ~ex_flush & ~ex_stall & ~w_hazard & if_valid;
  assign w_take        = w_accept & ~w_illegal;
  assign w_markIllegal = w_accept & w_illegal;
  assign w_countStall  = ~ex_flush & ~ex_stall & w_hazard;

  // Anything other than a legal accepted instruction loads the bubble encoding;
  // a stall without flush leaves the register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
      r_rd          <= 5'd0;
      r_imm         <= '0;
      r_ctrlEx      <= 6'd0;
      r_ctrlMem     <= 4'b1100;
      r_ctrlWb      <= 2'b00;
      r_link        <= 1'b0;
      r_jalr        <= 1'b0;
      r_illegal     <= 1'b0;
      r_illegalSeen <= 1'b0;
      r_stallCnt    <= '0;
    end else begin
      if (ex_flush || !ex_stall) begin
        r_valid   <= w_take;
        r_pc      <= w_take ? if_pc : '0;
        r_rs1     <= w_take ? w_rs1 : 5'd0;
        r_rs2     <= w_take ? w_rs2 : 5'd0;
        r_rd      <= w_take ? w_rd : 5'd0;
        r_imm     <= w_take ? w_imm : '0;
        r_ctrlEx  <= w_take ? {w_aluSrc, w_aluOp, w_regDst} : 6'd0;
        r_ctrlMem <= w_take ? {w_branch, w_jump, w_memWrite} : 4'b1100;
        r_ctrlWb  <= w_take ? {w_memToReg, w_regWrite} : 2'b00;
        r_link    <= w_take & w_link;
        r_jalr    <= w_take & w_jalr;
        r_illegal <= w_markIllegal;
      end
      if (w_markIllegal) begin
        r_illegalSeen <= 1'b1;
      end
      if (w_countStall && (r_stallCnt != {CNT_W{1'b1}})) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_rs1       = r_rs1;
  assign ex_rs2       = r_rs2;
  assign ex_rd        = r_rd;
  assign ex_imm       = r_imm;
  assign ex_ctrl_ex   = r_ctrlEx;
  assign ex_ctrl_mem  = r_ctrlMem;
  assign ex_ctrl_wb   = r_ctrlWb;
  assign ex_link      = r_link;
  assign ex_jalr      = r_jalr;
  assign ex_illegal   = r_illegal;
  assign illegal_seen = r_illegalSeen;
  assign stall_cnt    = r_stallCnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: a default instance, a JALR_EN=0 instance
// and a CNT_W=2 instance all share one stimulus stream.
module tb_decode_ctrl_pipe;

  localparam logic [31:0] I_ADDI   = 32'hFFB00093;
  localparam logic [31:0] I_BEQ    = 32'hFE000CE3;
  localparam logic [31:0] I_BADF3  = 32'hFE002CE3;
  localparam logic [31:0] I_LD5    = 32'h00013283;
  localparam logic [31:0] I_LD0    = 32'h00013003;
  localparam logic [31:0] I_LW5    = 32'h00012283;
  localparam logic [31:0] I_ADD657 = 32'h00728333;
  localparam logic [31:0] I_ADD607 = 32'h00700333;
  localparam logic [31:0] I_LUI    = 32'h12345237;
  localparam logic [31:0] I_JAL    = 32'h010000EF;
  localparam logic [31:0] I_JALR   = 32'h008180E7;

  logic        clk;
  logic        rstN;
  logic        ifValid;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic        exStall;
  logic        exFlush;
  logic [31:0] pcNext;

  logic        mReady, mValid, mLink, mJalr, mIllegal, mSeen;
  logic [31:0] mPc;
  logic [4:0]  mRs1, mRs2, mRd;
  logic [63:0] mImm;
  logic [5:0]  mCtrlEx;
  logic [3:0]  mCtrlMem;
  logic [1:0]  mCtrlWb;
  logic [15:0] mCnt;

  logic        jReady, jValid, jLink, jJalr, jIllegal, jSeen;
  logic [31:0] jPc;
  logic [4:0]  jRs1, jRs2, jRd;
  logic [63:0] jImm;
  logic [5:0]  jCtrlEx;
  logic [3:0]  jCtrlMem;
  logic [1:0]  jCtrlWb;
  logic [15:0] jCnt;

  logic        sReady, sValid, sLink, sJalr, sIllegal, sSeen;
  logic [31:0] sPc;
  logic [4:0]  sRs1, sRs2, sRd;
  logic [63:0] sImm;
  logic [5:0]  sCtrlEx;
  logic [3:0]  sCtrlMem;
  logic [1:0]  sCtrlWb;
  logic [1:0]  sCnt;

  int checks = 0;
  int errors = 0;

  decode_ctrl_pipe u_main (
    .clk(clk), .rst_n(rstN), .if_valid(ifValid), .if_instr(ifInstr), .if_pc(ifPc),
    .id_ready(mReady), .ex_stall(exStall), .ex_flush(exFlush), .ex_valid(mValid),
    .ex_pc(mPc), .ex_rs1(mRs1), .ex_rs2(mRs2), .ex_rd(mRd), .ex_imm(mImm),
    .ex_ctrl_ex(mCtrlEx), .ex_ctrl_mem(mCtrlMem), .ex_ctrl_wb(mCtrlWb),
    .ex_link(mLink), .ex_jalr(mJalr), .ex_illegal(mIllegal),
    .illegal_seen(mSeen), .stall_cnt(mCnt)
  );

  decode_ctrl_pipe #(.JALR_EN(0)) u_noJalr (
    .clk(clk), .rst_n(rstN), .if_valid(ifValid), .if_instr(ifInstr), .if_pc(ifPc),
    .id_ready(jReady), .ex_stall(exStall), .ex_flush(exFlush), .ex_valid(jValid),
    .ex_pc(jPc), .ex_rs1(jRs1), .ex_rs2(jRs2), .ex_rd(jRd), .ex_imm(jImm),
    .ex_ctrl_ex(jCtrlEx), .ex_ctrl_mem(jCtrlMem), .ex_ctrl_wb(jCtrlWb),
    .ex_link(jLink), .ex_jalr(jJalr), .ex_illegal(jIllegal),
    .illegal_seen(jSeen), .stall_cnt(jCnt)
  );

  decode_ctrl_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rstN), .if_valid(ifValid), .if_instr(ifInstr), .if_pc(ifPc),
    .id_ready(sReady), .ex_stall(exStall), .ex_flush(exFlush), .ex_valid(sValid),
    .ex_pc(sPc), .ex_rs1(sRs1), .ex_rs2(sRs2), .ex_rd(sRd), .ex_imm(sImm),
    .ex_ctrl_ex(sCtrlEx), .ex_ctrl_mem(sCtrlMem), .ex_ctrl_wb(sCtrlWb),
    .ex_link(sLink), .ex_jalr(sJalr), .ex_illegal(sIllegal),
    .illegal_seen(sSeen), .stall_cnt(sCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one fetch slot; the PC advances by 4 on every call.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic stall, input logic flush);
    ifValid = valid;
    ifInstr = instr;
    ifPc    = pcNext;
    exStall = stall;
    exFlush = flush;
    pcNext  = pcNext + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] addiPc;
    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) tick();
    rstN = 1'b1;
    tick();
    addiPc = pcNext;
    applyStimulus(1'b1, I_ADDI, 1'b0, 1'b0);
    tick();
    checks++; if (mValid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid: got %0b expected 1", mValid); end
    checks++; if (mPc !== addiPc) begin errors++; $display("[TB] FAIL pre_reset_pc: got %h expected %h", mPc, addiPc); end
    #2 rstN = 1'b0;
    #1;
    checks++; if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", mValid); end
    checks++; if (mCtrlMem !== 4'b1100) begin errors++; $display("[TB] FAIL reset_ctrl_mem: got %b expected 1100", mCtrlMem); end
    checks++; if (mImm !== 64'd0) begin errors++; $display("[TB] FAIL reset_imm: got %h expected 0", mImm); end
    checks++; if ({mCtrlEx, mCtrlWb, mRd} !== 13'd0) begin errors++; $display("[TB] FAIL reset_ctrl: got %h expected 0", {mCtrlEx, mCtrlWb, mRd}); end
    checks++; if (mCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", mCnt); end
    checks++; if (mSeen !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal_seen: got %0b expected 0", mSeen); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, I_ADDI, 1'b0, 1'b0);
    #1;
    checks++; if (mReady !== 1'b1) begin errors++; $display("[TB] FAIL addi_ready: got %0b expected 1", mReady); end
    tick();
    checks++; if (mImm !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("[TB] FAIL addi_imm: got %h expected fffffffffffffffb", mImm); end
    checks++; if (mCtrlWb !== 2'b01) begin errors++; $display("[TB] FAIL addi_ctrl_wb: got %b expected 01", mCtrlWb); end
    checks++; if (mCtrlEx !== 6'b100000) begin errors++; $display("[TB] FAIL addi_ctrl_ex: got %b expected 100000", mCtrlEx); end
    checks++; if (mRd !== 5'd1) begin errors++; $display("[TB] FAIL addi_rd: got %0d expected 1", mRd); end
    applyStimulus(1'b1, I_BEQ, 1'b0, 1'b0);
    tick();
    checks++; if (mValid !== 1'b1) begin errors++; $display("[TB] FAIL beq_valid: got %0b expected 1", mValid); end
    checks++; if (mImm !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("[TB] FAIL beq_imm: got %h expected fffffffffffffff8", mImm); end
    checks++; if (mCtrlMem !== 4'b0000) begin errors++; $display("[TB] FAIL beq_ctrl_mem: got %b expected 0000", mCtrlMem); end
    checks++; if (mCtrlWb !== 2'b00) begin errors++; $display("[TB] FAIL beq_ctrl_wb: got %b expected 00", mCtrlWb); end
    checks++; if (mCtrlEx !== 6'b010000) begin errors++; $display("[TB] FAIL beq_ctrl_ex: got %b expected 010000", mCtrlEx); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL idle_bubble: got %0b expected 0", mValid); end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, I_LD5, 1'b0, 1'b0);
    tick();
    checks++; if (mCtrlWb !== 2'b11 || mRd !== 5'd5) begin errors++; $display("[TB] FAIL ld_decode: got wb=%b rd=%0d expected wb=11 rd=5", mCtrlWb, mRd); end
    checks++; if (mCtrlEx !== 6'b100001) begin errors++; $display("[TB] FAIL ld_ctrl_ex: got %b expected 100001", mCtrlEx); end
    applyStimulus(1'b1, I_ADD657, 1'b0, 1'b0);
    #1;
    checks++; if (mReady !== 1'b0) begin errors++; $display("[TB] FAIL hazard_ready: got %0b expected 0", mReady); end
    tick();
    checks++; if (mValid !== 1'b0 || mCtrlMem !== 4'b1100) begin errors++; $display("[TB] FAIL hazard_bubble: got valid=%0b mem=%b expected valid=0 mem=1100", mValid, mCtrlMem); end
    checks++; if (mCnt !== 16'd1) begin errors++; $display("[TB] FAIL hazard_stall_cnt: got %0d expected 1", mCnt); end
    checks++; if (mReady !== 1'b1) begin errors++; $display("[TB] FAIL hazard_clear_ready: got %0b expected 1", mReady); end
    tick();
    checks++; if (mValid !== 1'b1 || mRd !== 5'd6 || mRs1 !== 5'd5 || mRs2 !== 5'd7) begin errors++; $display("[TB] FAIL add_after_bubble: got valid=%0b rd=%0d rs1=%0d rs2=%0d expected 1/6/5/7", mValid, mRd, mRs1, mRs2); end
    checks++; if (mCtrlWb !== 2'b01 || mCtrlEx !== 6'd0) begin errors++; $display("[TB] FAIL add_ctrl: got wb=%b ex=%b expected 01/000000", mCtrlWb, mCtrlEx); end
    applyStimulus(1'b1, I_LD0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, I_ADD607, 1'b0, 1'b0);
    #1;
    checks++; if (mReady !== 1'b1) begin errors++; $display("[TB] FAIL x0_load_ready: got %0b expected 1", mReady); end
    tick();
    checks++; if (mValid !== 1'b1 || mRd !== 5'd6) begin errors++; $display("[TB] FAIL x0_load_no_bubble: got valid=%0b rd=%0d expected 1/6", mValid, mRd); end
    checks++; if (mCnt !== 16'd1) begin errors++; $display("[TB] FAIL x0_load_stall_cnt: got %0d expected 1", mCnt); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_lui_jal();
    applyStimulus(1'b1, I_LUI, 1'b0, 1'b0);
    tick();
    checks++; if (mImm !== 64'h0000_0000_1234_5000) begin errors++; $display("[TB] FAIL lui_imm: got %h expected 0000000012345000", mImm); end
    checks++; if (mRs1 !== 5'd0 || mRd !== 5'd4) begin errors++; $display("[TB] FAIL lui_regs: got rs1=%0d rd=%0d expected 0/4", mRs1, mRd); end
    checks++; if (mCtrlEx !== 6'b100000 || mCtrlWb !== 2'b01) begin errors++; $display("[TB] FAIL lui_ctrl: got ex=%b wb=%b expected 100000/01", mCtrlEx, mCtrlWb); end
    applyStimulus(1'b1, I_JAL, 1'b0, 1'b0);
    tick();
    checks++; if (mImm !== 64'd16) begin errors++; $display("[TB] FAIL jal_imm: got %h expected 10", mImm); end
    checks++; if (mCtrlMem !== 4'b1110 || mLink !== 1'b1 || mJalr !== 1'b0) begin errors++; $display("[TB] FAIL jal_ctrl: got mem=%b link=%0b jalr=%0b expected 1110/1/0", mCtrlMem, mLink, mJalr); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_jalr();
    applyStimulus(1'b1, I_JALR, 1'b0, 1'b0);
    tick();
    checks++; if (mCtrlMem !== 4'b1110 || mLink !== 1'b1 || mJalr !== 1'b1) begin errors++; $display("[TB] FAIL jalr_ctrl: got mem=%b link=%0b jalr=%0b expected 1110/1/1", mCtrlMem, mLink, mJalr); end
    checks++; if (mImm !== 64'd8 || mRs1 !== 5'd3 || mCtrlEx !== 6'b100000) begin errors++; $display("[TB] FAIL jalr_decode: got imm=%h rs1=%0d ex=%b expected 8/3/100000", mImm, mRs1, mCtrlEx); end
    checks++; if (mIllegal !== 1'b0 || mSeen !== 1'b0) begin errors++; $display("[TB] FAIL jalr_legal: got illegal=%0b seen=%0b expected 0/0", mIllegal, mSeen); end
    checks++; if (jValid !== 1'b0 || jIllegal !== 1'b1 || jSeen !== 1'b1) begin errors++; $display("[TB] FAIL nojalr_illegal: got valid=%0b illegal=%0b seen=%0b expected 0/1/1", jValid, jIllegal, jSeen); end
    checks++; if (jCtrlMem !== 4'b1100 || jLink !== 1'b0) begin errors++; $display("[TB] FAIL nojalr_bubble: got mem=%b link=%0b expected 1100/0", jCtrlMem, jLink); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (jIllegal !== 1'b0 || jSeen !== 1'b1) begin errors++; $display("[TB] FAIL nojalr_sticky: got illegal=%0b seen=%0b expected 0/1", jIllegal, jSeen); end
    applyStimulus(1'b1, I_BADF3, 1'b0, 1'b0);
    tick();
    checks++; if (mValid !== 1'b0 || mIllegal !== 1'b1 || mSeen !== 1'b1) begin errors++; $display("[TB] FAIL branch_bad_f3: got valid=%0b illegal=%0b seen=%0b expected 0/1/1", mValid, mIllegal, mSeen); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, I_ADDI, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, I_LW5, 1'b1, 1'b1);
    #1;
    checks++; if (mReady !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready: got %0b expected 1", mReady); end
    tick();
    checks++; if (mValid !== 1'b0 || mCtrlMem !== 4'b1100 || mImm !== 64'd0) begin errors++; $display("[TB] FAIL flush_bubble: got valid=%0b mem=%b imm=%h expected 0/1100/0", mValid, mCtrlMem, mImm); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (mValid !== 1'b0 || mRd !== 5'd0) begin errors++; $display("[TB] FAIL flush_dropped: got valid=%0b rd=%0d expected 0/0", mValid, mRd); end
  endtask

  task automatic test_hazard_stall();
    applyStimulus(1'b1, I_LD5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, I_ADD657, 1'b1, 1'b0);
    #1;
    checks++; if (mReady !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready: got %0b expected 0", mReady); end
    tick();
    checks++; if (mValid !== 1'b1 || mRd !== 5'd5 || mCtrlWb !== 2'b11) begin errors++; $display("[TB] FAIL stall_hold: got valid=%0b rd=%0d wb=%b expected 1/5/11", mValid, mRd, mCtrlWb); end
    checks++; if (mCnt !== 16'd1) begin errors++; $display("[TB] FAIL stall_no_count: got %0d expected 1", mCnt); end
    applyStimulus(1'b1, I_ADD657, 1'b0, 1'b0);
    tick();
    checks++; if (mValid !== 1'b0 || mCnt !== 16'd2) begin errors++; $display("[TB] FAIL unstall_bubble: got valid=%0b cnt=%0d expected 0/2", mValid, mCnt); end
    tick();
    checks++; if (mValid !== 1'b1 || mRd !== 5'd6) begin errors++; $display("[TB] FAIL unstall_add: got valid=%0b rd=%0d expected 1/6", mValid, mRd); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] expSat;
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, I_LD5, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, I_ADD657, 1'b0, 1'b0);
      tick();
      tick();
      expSat = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++; if (sCnt !== expSat) begin errors++; $display("[TB] FAIL sat_cnt_pair%0d: got %0d expected %0d", i, sCnt, expSat); end
    end
    checks++; if (mCnt !== 16'd5) begin errors++; $display("[TB] FAIL wide_cnt: got %0d expected 5", mCnt); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    pcNext  = 32'h0000_1000;
    rstN    = 1'b0;
    ifValid = 1'b0;
    ifInstr = 32'h0;
    ifPc    = 32'h0;
    exStall = 1'b0;
    exFlush = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_lui_jal();
    test_jalr();
    test_flush();
    test_hazard_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
